// File: rtl/memory_stage_pkg.sv
// Shared encodings and helpers for the memory stage.
// Bit numbering is big-endian: bit 0 is the MSB of every vector.
package memory_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 6;
  localparam int unsigned BE_W    = 4;

  localparam logic [0:1] SZ_WORD = 2'b00;
  localparam logic [0:1] SZ_HALF = 2'b01;
  localparam logic [0:1] SZ_BYTE = 2'b10;

  localparam logic [0:1] SRC_ALU = 2'b00;
  localparam logic [0:1] SRC_MEM = 2'b01;
  localparam logic [0:1] SRC_FPU = 2'b10;
  localparam logic [0:1] SRC_PC4 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // off is addr[30:31]; size 11 behaves as a word access
  function automatic logic is_misaligned(input logic [0:1] off, input logic [0:1] size);
    logic r;
    case (size)
      SZ_HALF: r = off[1];
      SZ_BYTE: r = 1'b0;
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_lane_align.sv
// Byte-lane steering for stores and lane extraction plus extension for loads.
module mem_lane_align
  import memory_stage_pkg::*;
(
  input  logic [0:1]        i_off,
  input  logic [0:1]        i_size,
  input  logic              i_ext,
  input  logic [0:DATA_W-1] i_wdata,
  input  logic [0:DATA_W-1] i_rdata,
  output logic [0:BE_W-1]   o_byte_en,
  output logic [0:DATA_W-1] o_wdata,
  output logic [0:DATA_W-1] o_ldata,
  output logic              o_misalign
);

  logic [0:15] w_half;
  logic [0:7]  w_byte;

  always_comb begin
    w_half = i_off[0] ? i_rdata[16:31] : i_rdata[0:15];
    case (i_off)
      2'b00:   w_byte = i_rdata[0:7];
      2'b01:   w_byte = i_rdata[8:15];
      2'b10:   w_byte = i_rdata[16:23];
      default: w_byte = i_rdata[24:31];
    endcase
  end

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    o_ldata   = i_rdata;
    case (i_size)
      SZ_HALF: begin
        o_byte_en = i_off[0] ? 4'b0011 : 4'b1100;
        o_wdata   = {2{i_wdata[16:31]}};
        o_ldata   = {{16{i_ext & w_half[0]}}, w_half};
      end
      SZ_BYTE: begin
        o_byte_en = 4'b1000 >> i_off;
        o_wdata   = {4{i_wdata[24:31]}};
        o_ldata   = {{24{i_ext & w_byte[0]}}, w_byte};
      end
      default: ;
    endcase
  end

  assign o_misalign = is_misaligned(i_off, i_size);

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: latches execute results, runs the data-memory
// handshake and holds the pipeline while the access is outstanding.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [0:DATA_W-1]   NextALUOut,
  input  logic [0:DATA_W-1]   NextFPUOut,
  input  logic [0:DATA_W-1]   NextRegB,
  input  logic [0:DATA_W-1]   NextPCPlusFour,
  input  logic [0:1]          NextDInSrc,
  input  logic                NextRegWE,
  input  logic [0:RADDR_W-1]  NextRegWAddr,
  input  logic [0:1]          NextMEMSize,
  input  logic                NextMEMWE,
  input  logic                NextExtMEM,
  output logic [0:DATA_W-1]   DMemAddr,
  output logic [0:DATA_W-1]   DMemWData,
  output logic [0:BE_W-1]     DMemByteEn,
  output logic                DMemReq,
  output logic                DMemWE,
  input  logic                DMemReady,
  input  logic [0:DATA_W-1]   DMemRData,
  output logic                MemStall,
  output logic                Misalign,
  output logic [0:DATA_W-1]   ALUOut,
  output logic [0:DATA_W-1]   FPUOut,
  output logic [0:DATA_W-1]   PCPlusFour,
  output logic [0:DATA_W-1]   MemOut,
  output logic [0:1]          DInSrc,
  output logic                RegWE,
  output logic [0:RADDR_W-1]  RegWAddr
);

  state_t               r_state, w_state_next;
  logic [0:DATA_W-1]    r_alu, r_fpu, r_regb, r_pc4, r_load_q;
  logic [0:1]           r_dinsrc, r_size;
  logic                 r_regwe, r_memwe, r_ext;
  logic [0:RADDR_W-1]   r_waddr;

  logic                 w_adv, w_need_access, w_capture, w_misal, w_mem_op;
  logic [0:DATA_W-1]    w_rsrc, w_wdata, w_ldata;
  logic [0:BE_W-1]      w_byte_en;

  assign w_need_access = (NextMEMWE || (NextDInSrc == SRC_MEM)) &&
                         !is_misaligned(NextALUOut[30:31], NextMEMSize);
  assign w_adv     = !stall && !MemStall;
  assign w_capture = !w_adv && (r_state == ST_ACCESS) && DMemReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_adv)          w_state_next = w_need_access ? ST_ACCESS : ST_IDLE;
    else if (w_capture) w_state_next = ST_DONE;
  end

  // Stage register; frozen whenever the stage cannot advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu    <= '0;
      r_fpu    <= '0;
      r_regb   <= '0;
      r_pc4    <= '0;
      r_dinsrc <= '0;
      r_regwe  <= 1'b0;
      r_waddr  <= '0;
      r_size   <= '0;
      r_memwe  <= 1'b0;
      r_ext    <= 1'b0;
      r_load_q <= '0;
    end else if (w_adv) begin
      r_alu    <= NextALUOut;
      r_fpu    <= NextFPUOut;
      r_regb   <= NextRegB;
      r_pc4    <= NextPCPlusFour;
      r_dinsrc <= NextDInSrc;
      r_regwe  <= NextRegWE;
      r_waddr  <= NextRegWAddr;
      r_size   <= NextMEMSize;
      r_memwe  <= NextMEMWE;
      r_ext    <= NextExtMEM;
    end else if (w_capture) begin
      r_load_q <= DMemRData;
    end
  end

  assign w_rsrc = (r_state == ST_DONE) ? r_load_q : DMemRData;

  mem_lane_align u_align (
    .i_off      (r_alu[30:31]),
    .i_size     (r_size),
    .i_ext      (r_ext),
    .i_wdata    (r_regb),
    .i_rdata    (w_rsrc),
    .o_byte_en  (w_byte_en),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_misal)
  );

  assign w_mem_op = r_memwe || (r_dinsrc == SRC_MEM);

  always_comb begin
    DMemReq    = (r_state == ST_ACCESS);
    DMemWE     = DMemReq && r_memwe;
    MemStall   = DMemReq && !DMemReady;
    DMemByteEn = DMemReq ? w_byte_en : '0;
    DMemWData  = DMemReq ? w_wdata : '0;
    Misalign   = w_misal && w_mem_op;
    MemOut     = (r_state == ST_IDLE) ? '0 : w_ldata;
    RegWE      = r_regwe && !MemStall && !Misalign;
  end

  assign DMemAddr   = r_alu;
  assign ALUOut     = r_alu;
  assign FPUOut     = r_fpu;
  assign PCPlusFour = r_pc4;
  assign DInSrc     = r_dinsrc;
  assign RegWAddr   = r_waddr;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [0:31] NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour;
  logic [0:1]  NextDInSrc, NextMEMSize;
  logic        NextRegWE, NextMEMWE, NextExtMEM;
  logic [0:5]  NextRegWAddr;
  logic [0:31] DMemAddr, DMemWData, DMemRData;
  logic [0:3]  DMemByteEn;
  logic        DMemReq, DMemWE, DMemReady, MemStall, Misalign;
  logic [0:31] ALUOut, FPUOut, PCPlusFour, MemOut;
  logic [0:1]  DInSrc;
  logic        RegWE;
  logic [0:5]  RegWAddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut), .NextRegB(NextRegB),
    .NextPCPlusFour(NextPCPlusFour), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
    .NextRegWAddr(NextRegWAddr), .NextMEMSize(NextMEMSize), .NextMEMWE(NextMEMWE),
    .NextExtMEM(NextExtMEM), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemByteEn(DMemByteEn), .DMemReq(DMemReq), .DMemWE(DMemWE),
    .DMemReady(DMemReady), .DMemRData(DMemRData), .MemStall(MemStall),
    .Misalign(Misalign), .ALUOut(ALUOut), .FPUOut(FPUOut), .PCPlusFour(PCPlusFour),
    .MemOut(MemOut), .DInSrc(DInSrc), .RegWE(RegWE), .RegWAddr(RegWAddr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    NextALUOut = '0; NextFPUOut = '0; NextRegB = '0; NextPCPlusFour = '0;
    NextDInSrc = 2'b00; NextMEMSize = 2'b00; NextRegWE = 1'b0; NextMEMWE = 1'b0;
    NextExtMEM = 1'b0; NextRegWAddr = '0;
  endtask

  task automatic set_load(input logic [0:31] addr, input logic [0:1] size,
                          input logic ext, input logic [0:5] waddr);
    set_nop();
    NextALUOut = addr; NextMEMSize = size; NextExtMEM = ext;
    NextDInSrc = 2'b01; NextRegWE = 1'b1; NextRegWAddr = waddr;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; DMemReady = 1'b0; DMemRData = '0;
    set_nop();
    #12;
    vectors++; if (DMemReq !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", DMemReq); end
    vectors++; if (MemStall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", MemStall); end
    vectors++; if (RegWE !== 1'b0 || Misalign !== 1'b0) begin miscompares++; $display("FAIL rst_flags got %b%b want 00", RegWE, Misalign); end
    vectors++; if ({ALUOut, MemOut, DMemWData} !== 96'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", {ALUOut, MemOut, DMemWData}); end
    vectors++; if (DMemByteEn !== 4'b0000) begin miscompares++; $display("FAIL rst_be got %b want 0000", DMemByteEn); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    DMemReady = 1'b1;
    set_load(32'h103, 2'b10, 1'b1, 6'd5);
    NextFPUOut = 32'h1111_1111; NextPCPlusFour = 32'h2000;
    DMemRData = 32'h1122_33F0;
    tick();
    vectors++; if (DMemByteEn !== 4'b0001) begin miscompares++; $display("FAIL bload_be got %b want 0001", DMemByteEn); end
    vectors++; if (MemOut !== 32'hFFFF_FFF0) begin miscompares++; $display("FAIL bload_out got %h want fffffff0", MemOut); end
    vectors++; if (MemStall !== 1'b0 || DMemReq !== 1'b1 || DMemWE !== 1'b0) begin miscompares++; $display("FAIL bload_hs got %b%b%b want 010", MemStall, DMemReq, DMemWE); end
    vectors++; if (RegWE !== 1'b1 || RegWAddr !== 6'd5 || DInSrc !== 2'b01) begin miscompares++; $display("FAIL bload_wb got %b %0d %b want 1 5 01", RegWE, RegWAddr, DInSrc); end
    vectors++; if (FPUOut !== 32'h1111_1111 || PCPlusFour !== 32'h2000) begin miscompares++; $display("FAIL bload_pass got %h %h", FPUOut, PCPlusFour); end
    set_load(32'h102, 2'b01, 1'b1, 6'd6);
    DMemRData = 32'h1234_8001;
    tick();
    vectors++; if (MemOut !== 32'hFFFF_8001 || MemStall !== 1'b0) begin miscompares++; $display("FAIL hload got %h st %b want ffff8001 0", MemOut, MemStall); end
    set_load(32'h101, 2'b10, 1'b0, 6'd7);
    DMemRData = 32'h11AB_3344;
    tick();
    vectors++; if (MemOut !== 32'h0000_00AB || DMemByteEn !== 4'b0100) begin miscompares++; $display("FAIL bload_zx got %h %b want 000000ab 0100", MemOut, DMemByteEn); end
    set_nop();
    tick();
    vectors++; if (DMemReq !== 1'b0 || MemOut !== 32'h0) begin miscompares++; $display("FAIL idle_after got %b %h want 0 0", DMemReq, MemOut); end
  endtask

  task automatic test_half_store();
    DMemReady = 1'b1;
    set_nop();
    NextALUOut = 32'h202; NextRegB = 32'h0000_ABCD; NextMEMWE = 1'b1; NextMEMSize = 2'b01;
    tick();
    vectors++; if (DMemWE !== 1'b1 || DMemReq !== 1'b1) begin miscompares++; $display("FAIL hstore_we got %b%b want 11", DMemWE, DMemReq); end
    vectors++; if (DMemByteEn !== 4'b0011) begin miscompares++; $display("FAIL hstore_be got %b want 0011", DMemByteEn); end
    vectors++; if (DMemWData !== 32'hABCD_ABCD || DMemAddr !== 32'h202) begin miscompares++; $display("FAIL hstore_data got %h @%h want abcdabcd @202", DMemWData, DMemAddr); end
    set_nop();
    tick();
  endtask

  task automatic test_wait_load();
    DMemReady = 1'b0; DMemRData = 32'hDEAD_BEEF;
    set_load(32'h100, 2'b00, 1'b0, 6'd7);
    tick();
    set_nop(); NextALUOut = 32'h555;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (MemStall !== 1'b1 || RegWE !== 1'b0) begin miscompares++; $display("FAIL wait_stall[%0d] got %b %b want 1 0", i, MemStall, RegWE); end
      vectors++; if (ALUOut !== 32'h100) begin miscompares++; $display("FAIL wait_frozen[%0d] got %h want 100", i, ALUOut); end
      tick();
    end
    DMemReady = 1'b1;
    #1;
    vectors++; if (MemStall !== 1'b0 || RegWE !== 1'b1 || MemOut !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wait_done got %b %b %h want 0 1 deadbeef", MemStall, RegWE, MemOut); end
    tick();
    vectors++; if (ALUOut !== 32'h555 || DMemReq !== 1'b0) begin miscompares++; $display("FAIL wait_adv got %h %b want 555 0", ALUOut, DMemReq); end
  endtask

  task automatic test_stall_done();
    DMemReady = 1'b0;
    set_load(32'h104, 2'b00, 1'b0, 6'd9);
    tick();
    set_nop(); NextALUOut = 32'h777;
    stall = 1'b1; DMemReady = 1'b1; DMemRData = 32'hCAFE_F00D;
    #1;
    vectors++; if (MemOut !== 32'hCAFE_F00D || MemStall !== 1'b0) begin miscompares++; $display("FAIL sd_access got %h %b want cafef00d 0", MemOut, MemStall); end
    tick();
    DMemReady = 1'b0; DMemRData = 32'h0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (DMemReq !== 1'b0 || MemOut !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL sd_done[%0d] got %b %h want 0 cafef00d", i, DMemReq, MemOut); end
      vectors++; if (ALUOut !== 32'h104 || RegWE !== 1'b1) begin miscompares++; $display("FAIL sd_hold[%0d] got %h %b want 104 1", i, ALUOut, RegWE); end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    vectors++; if (ALUOut !== 32'h777 || MemOut !== 32'h0 || DMemReq !== 1'b0) begin miscompares++; $display("FAIL sd_adv got %h %h %b want 777 0 0", ALUOut, MemOut, DMemReq); end
  endtask

  task automatic test_misalign();
    DMemReady = 1'b1;
    set_load(32'h101, 2'b00, 1'b0, 6'd3);
    tick();
    vectors++; if (DMemReq !== 1'b0 || Misalign !== 1'b1 || RegWE !== 1'b0) begin miscompares++; $display("FAIL mis_word got %b %b %b want 0 1 0", DMemReq, Misalign, RegWE); end
    set_nop();
    NextALUOut = 32'h203; NextMEMWE = 1'b1; NextMEMSize = 2'b01; NextRegB = 32'h1234;
    tick();
    vectors++; if (DMemReq !== 1'b0 || DMemWE !== 1'b0 || Misalign !== 1'b1) begin miscompares++; $display("FAIL mis_half got %b %b %b want 0 0 1", DMemReq, DMemWE, Misalign); end
    set_nop();
    tick();
    vectors++; if (Misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear got %b want 0", Misalign); end
  endtask

  task automatic test_reset_mid_access();
    DMemReady = 1'b0;
    set_load(32'h108, 2'b00, 1'b0, 6'd4);
    tick();
    set_nop();
    vectors++; if (DMemReq !== 1'b1 || MemStall !== 1'b1) begin miscompares++; $display("FAIL rma_pre got %b %b want 1 1", DMemReq, MemStall); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (DMemReq !== 1'b0 || MemStall !== 1'b0 || RegWE !== 1'b0) begin miscompares++; $display("FAIL rma_async got %b %b %b want 0 0 0", DMemReq, MemStall, RegWE); end
    #2 reset = 1'b0;
    tick();
    vectors++; if (DMemReq !== 1'b0 || ALUOut !== 32'h0) begin miscompares++; $display("FAIL rma_idle got %b %h want 0 0", DMemReq, ALUOut); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_half_store();
    test_wait_load();
    test_stall_done();
    test_misalign();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
